// File: rtl/room_thermal_model_if.sv
// Command/observation bundle between an air-conditioning controller (master)
// and the room model (slave), plus a debug view of the model's mode register.
interface room_thermal_model_if;
  // No valid/ready handshake: every signal is level-sampled on each rising clk
  // edge, and every output is a registered value that is valid in every cycle.
  logic       heating;
  logic       cooling;
  logic       load;
  logic [4:0] load_value;
  logic [4:0] temperature;
  logic       changed;
  logic       fault;
  logic [1:0] dbg_mode;

  modport master (
    output heating, cooling, load, load_value,
    input  temperature, changed, fault, dbg_mode
  );

  modport slave (
    input  heating, cooling, load, load_value,
    output temperature, changed, fault, dbg_mode
  );
endinterface

// File: rtl/room_thermal_model.sv
// Room temperature model: heats, cools or drifts toward ambient one degree per
// prescaler period, with a load port that forces a temperature for test setups.
module room_thermal_model #(
  parameter int unsigned TEMP_INIT = 20,
  parameter int unsigned AMBIENT   = 15,
  parameter int unsigned HEAT_DIV  = 4,
  parameter int unsigned COOL_DIV  = 4,
  parameter int unsigned DRIFT_DIV = 16
) (
  input logic               clk,
  input logic               rst,
  room_thermal_model_if.slave bus
);

  typedef enum logic [1:0] {
    DRIFT = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2
  } mode_t;

  localparam logic [4:0] TEMP_RST = 5'(TEMP_INIT);
  localparam logic [4:0] AMB      = 5'(AMBIENT);
  localparam logic [7:0] HEAT_TC  = 8'(HEAT_DIV - 1);
  localparam logic [7:0] COOL_TC  = 8'(COOL_DIV - 1);
  localparam logic [7:0] DRIFT_TC = 8'(DRIFT_DIV - 1);

  mode_t      r_mode;
  logic [7:0] r_cnt;
  logic [4:0] r_temp;
  logic       r_changed;
  logic       r_fault;

  mode_t      w_req;
  logic [7:0] w_tc;
  logic [4:0] w_step_temp;
  logic       w_conflict;

  always_comb begin
    w_conflict = bus.heating && bus.cooling;
    w_req      = DRIFT;
    if (bus.heating && !bus.cooling)      w_req = HEAT;
    else if (bus.cooling && !bus.heating) w_req = COOL;
  end

  // Bounds are checked before each +/-1 so the 5-bit value never wraps.
  always_comb begin
    w_tc        = DRIFT_TC;
    w_step_temp = r_temp;
    case (r_mode)
      HEAT: begin
        w_tc = HEAT_TC;
        if (r_temp != 5'd31) w_step_temp = r_temp + 5'd1;
      end
      COOL: begin
        w_tc = COOL_TC;
        if (r_temp != 5'd0) w_step_temp = r_temp - 5'd1;
      end
      default: begin
        w_tc = DRIFT_TC;
        if (r_temp < AMB)      w_step_temp = r_temp + 5'd1;
        else if (r_temp > AMB) w_step_temp = r_temp - 5'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_temp    <= TEMP_RST;
      r_mode    <= DRIFT;
      r_cnt     <= 8'd0;
      r_changed <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_fault <= w_conflict;
      if (bus.load) begin
        r_temp    <= bus.load_value;
        r_cnt     <= 8'd0;
        r_mode    <= w_req;
        r_changed <= 1'b1;
      end else if (w_req != r_mode) begin
        // Any command toggle, even a one-cycle glitch, restarts the period.
        r_mode    <= w_req;
        r_cnt     <= 8'd0;
        r_changed <= 1'b0;
      end else if (r_cnt == w_tc) begin
        r_cnt     <= 8'd0;
        r_temp    <= w_step_temp;
        r_changed <= (w_step_temp != r_temp);
      end else begin
        r_cnt     <= r_cnt + 8'd1;
        r_changed <= 1'b0;
      end
    end
  end

  assign bus.temperature = r_temp;
  assign bus.changed     = r_changed;
  assign bus.fault       = r_fault;
  assign bus.dbg_mode    = r_mode;

endmodule

// File: tb/tb_room_thermal_model.sv
// Self-checking bench for room_thermal_model: directed scenarios and random
// command runs, every cycle compared against a behavioural room model.
module tb_room_thermal_model;

  localparam int TEMP_INIT = 20;
  localparam int AMBIENT   = 15;
  localparam int HEAT_DIV  = 4;
  localparam int COOL_DIV  = 4;
  localparam int DRIFT_DIV = 16;

  localparam int M_DRIFT = 0;
  localparam int M_HEAT  = 1;
  localparam int M_COOL  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  room_thermal_model_if bus ();

  room_thermal_model #(
    .TEMP_INIT (TEMP_INIT),
    .AMBIENT   (AMBIENT),
    .HEAT_DIV  (HEAT_DIV),
    .COOL_DIV  (COOL_DIV),
    .DRIFT_DIV (DRIFT_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  int fault_cnt = 0;

  // behavioural room: temperature, current activity, edges spent in it
  int m_temp  = TEMP_INIT;
  int m_mode  = M_DRIFT;
  int m_since = 0;
  int m_chg   = 0;
  int m_flt   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int period_of(input int m);
    if (m == M_HEAT) return HEAT_DIV;
    if (m == M_COOL) return COOL_DIV;
    return DRIFT_DIV;
  endfunction

  task automatic model_edge(input bit r, input bit h, input bit c, input bit l, input int lv);
    int req;
    int next;
    if (r) begin
      m_temp = TEMP_INIT; m_mode = M_DRIFT; m_since = 0; m_chg = 0; m_flt = 0;
      return;
    end
    m_flt = (h && c) ? 1 : 0;
    req = (h && !c) ? M_HEAT : ((c && !h) ? M_COOL : M_DRIFT);
    if (l) begin
      m_temp = lv; m_since = 0; m_mode = req; m_chg = 1;
    end else if (req != m_mode) begin
      m_mode = req; m_since = 0; m_chg = 0;
    end else begin
      m_since++;
      m_chg = 0;
      if (m_since == period_of(m_mode)) begin
        m_since = 0;
        next = m_temp;
        if (m_mode == M_HEAT)      next = (m_temp < 31) ? m_temp + 1 : 31;
        else if (m_mode == M_COOL) next = (m_temp > 0) ? m_temp - 1 : 0;
        else if (m_temp < AMBIENT) next = m_temp + 1;
        else if (m_temp > AMBIENT) next = m_temp - 1;
        m_chg  = (next != m_temp) ? 1 : 0;
        m_temp = next;
      end
    end
  endtask

  // driver: apply inputs before the edge, update model at the edge, check after
  task automatic drive(input bit r, input bit h, input bit c, input bit l, input int lv);
    rst            = r;
    bus.heating    = h;
    bus.cooling    = c;
    bus.load       = l;
    bus.load_value = 5'(lv);
    @(posedge clk);
    model_edge(r, h, c, l, lv);
    #1;
    check_eq("temperature", int'(bus.temperature), m_temp);
    check_eq("changed", int'(bus.changed), m_chg);
    check_eq("fault", int'(bus.fault), m_flt);
    if (bus.changed) pulse_cnt++;
    if (bus.fault) fault_cnt++;
  endtask

  task automatic hold(input bit h, input bit c, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, h, c, 1'b0, 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.heating    = 1'b0;
    bus.cooling    = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = 5'd0;

    // reset with heating held, and a load that must be ignored
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 7);
    check_eq("reset_temp", int'(bus.temperature), 20);
    check_eq("reset_changed", int'(bus.changed), 0);
    check_eq("reset_fault", int'(bus.fault), 0);
    hold(1'b1, 1'b0, 4);
    check_eq("post_reset_no_step", int'(bus.temperature), 20);
    hold(1'b1, 1'b0, 1);
    check_eq("post_reset_first_step", int'(bus.temperature), 21);

    // heat ramp from 17
    drive(1'b0, 1'b0, 1'b0, 1'b1, 17);
    check_eq("heat_load", int'(bus.temperature), 17);
    pulse_cnt = 0;
    hold(1'b1, 1'b0, 21);
    check_eq("heat_final", int'(bus.temperature), 22);
    check_eq("heat_pulses", pulse_cnt, 5);

    // cool into the floor
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
    pulse_cnt = 0;
    hold(1'b0, 1'b1, 20);
    check_eq("cool_floor", int'(bus.temperature), 0);
    check_eq("cool_pulses", pulse_cnt, 1);

    // heat into the ceiling
    drive(1'b0, 1'b1, 1'b0, 1'b1, 30);
    pulse_cnt = 0;
    hold(1'b1, 1'b0, 16);
    check_eq("heat_ceiling", int'(bus.temperature), 31);
    check_eq("heat_ceiling_pulses", pulse_cnt, 1);

    // drift down then up toward ambient
    drive(1'b0, 1'b0, 1'b0, 1'b1, 17);
    pulse_cnt = 0;
    hold(1'b0, 1'b0, 48);
    check_eq("drift_down", int'(bus.temperature), 15);
    check_eq("drift_down_pulses", pulse_cnt, 2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 64);
    check_eq("drift_up", int'(bus.temperature), 15);

    // conflict: fault for exactly as long as the conflict, one edge late
    drive(1'b0, 1'b0, 1'b0, 1'b1, 18);
    fault_cnt = 0;
    hold(1'b1, 1'b1, 3);
    hold(1'b0, 1'b0, 2);
    check_eq("conflict_fault_cycles", fault_cnt, 3);

    // load + heating on one edge, then a one-cycle glitch at cnt==2
    drive(1'b0, 1'b1, 1'b0, 1'b1, 10);
    check_eq("load_heat_value", int'(bus.temperature), 10);
    hold(1'b1, 1'b0, 2);
    hold(1'b0, 1'b0, 1);
    hold(1'b1, 1'b0, 4);
    check_eq("glitch_no_step", int'(bus.temperature), 10);
    hold(1'b1, 1'b0, 1);
    check_eq("glitch_step", int'(bus.temperature), 11);

    // random command runs with occasional loads and resets
    for (int run = 0; run < 150; run++) begin
      int cmd;
      int len;
      cmd = $urandom_range(0, 3);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        bit r;
        bit l;
        r = ($urandom_range(0, 255) == 0);
        l = ($urandom_range(0, 31) == 0);
        drive(r, cmd[0], cmd[1], l, $urandom_range(0, 31));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
